// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the SLC-3 memory arbiter.
//   arb_state_t     - arbiter FSM states
//   req_id_t        - requester identity (CPU datapath or program loader)
//   IO_ADDR_DEFAULT - word address decoded as memory-mapped I/O
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,  // folded into the IDLE->ACCESS/IO edge, never occupied
    ST_ACCESS = 3'd2,
    ST_IO     = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// wait_counter: 4-bit loadable down-counter that paces SRAM wait states.
//   clk, rst_n - clock and asynchronous active-low reset
//   load       - load load_val (has priority over dec)
//   load_val   - value loaded on load
//   dec        - decrement by one; saturates at zero
//   count      - current count
//   zero       - count equals zero
module wait_counter
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_d;
  logic [3:0] count_q;

  // Next-count selection: load, saturating decrement, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and loader memory requests onto the board SRAM
// with a fixed wait-state count, and decodes one I/O word (switch read,
// hex-display write).
//   Clk, Reset              - clock; asynchronous active-low reset
//   cpu_*/ldr_*             - req, we, addr, wdata in; one-cycle ack out
//   rdata                   - registered read data, held until next read
//   sw / hex_out            - switch inputs / display register
//   mem_ce_n/oe_n/we_n      - registered active-low SRAM strobes
//   mem_addr/wdata/rdata    - SRAM address, write data, read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        ldr_req,
  input  logic        cpu_we,
  input  logic        ldr_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [15:0] ldr_wdata,
  output logic        cpu_ack,
  output logic        ldr_ack,
  output logic [15:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] hex_out,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t  state_d, state_q;
  req_id_t     grant_d, grant_q;
  req_id_t     last_grant_d, last_grant_q;
  req_id_t     win_s;
  logic        we_d, we_q;
  logic [15:0] addr_d, addr_q;
  logic [15:0] wdata_d, wdata_q;
  logic [15:0] rdata_d, rdata_q;
  logic [15:0] hex_d, hex_q;
  logic        cpu_ack_d, cpu_ack_q;
  logic        ldr_ack_d, ldr_ack_q;
  logic        ce_n_d, ce_n_q;
  logic        oe_n_d, oe_n_q;
  logic        we_n_d, we_n_q;
  logic [15:0] maddr_d, maddr_q;
  logic [15:0] mwdata_d, mwdata_q;
  logic        cnt_load_s;
  logic        cnt_dec_s;
  logic        cnt_zero_s;
  logic [3:0]  cnt_val_s;

  wait_counter u_wait_counter (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load_s),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec_s),
    .count    (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // FSM next state, operand latching and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    win_s        = REQ_CPU;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    hex_d        = hex_q;
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || ldr_req) begin
          // Tie goes to whoever was not served last.
          if (cpu_req && ldr_req) begin
            win_s = (last_grant_q == REQ_LDR) ? REQ_CPU : REQ_LDR;
          end else if (cpu_req) begin
            win_s = REQ_CPU;
          end else begin
            win_s = REQ_LDR;
          end
          grant_d = win_s;
          if (win_s == REQ_CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end
          if (addr_d == IO_ADDR) begin
            state_d = ST_IO;
          end else begin
            state_d    = ST_ACCESS;
            cnt_load_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero_s) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_DONE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_IO: begin
        if (we_q) begin
          hex_d = wdata_q;
        end else begin
          rdata_d = sw;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cpu_ack_d = (state_d == ST_DONE) && (grant_d == REQ_CPU);
    ldr_ack_d = (state_d == ST_DONE) && (grant_d == REQ_LDR);
    ce_n_d    = !(state_d == ST_ACCESS);
    oe_n_d    = !((state_d == ST_ACCESS) && !we_d);
    we_n_d    = !((state_d == ST_ACCESS) && we_d);
    maddr_d   = (state_d == ST_ACCESS) ? addr_d : maddr_q;
    mwdata_d  = ((state_d == ST_ACCESS) && we_d) ? wdata_d : mwdata_q;
  end

  // State, operand and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_LDR;
      last_grant_q <= REQ_LDR;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
      hex_q        <= 16'h0000;
      cpu_ack_q    <= 1'b0;
      ldr_ack_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      maddr_q      <= 16'h0000;
      mwdata_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      hex_q        <= hex_d;
      cpu_ack_q    <= cpu_ack_d;
      ldr_ack_q    <= ldr_ack_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign rdata     = rdata_q;
  assign hex_out   = hex_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with an asynchronous SRAM
// model on the default (2 wait-state) instance, plus 1- and 15-wait-state
// instances whose SRAM returns address ^ 16'h5A5A.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, ldr_req, cpu_we, ldr_we;
  logic [15:0] cpu_addr, ldr_addr, cpu_wdata, ldr_wdata;
  logic        cpu_ack, ldr_ack;
  logic [15:0] rdata, sw, hex_out;
  logic        mem_ce_n, mem_oe_n, mem_we_n;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] sram [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  logic        req_w1, req_w15;
  logic        cack_w1, lack_w1, ce_w1, oe_w1, we_w1;
  logic        cack_w15, lack_w15, ce_w15, oe_w15, we_w15;
  logic [15:0] rd_w1, hex_w1, ma_w1, mwd_w1;
  logic [15:0] rd_w15, hex_w15, ma_w15, mwd_w15;

  int vec_cnt;
  int err_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter dut (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req), .ldr_req(ldr_req), .cpu_we(cpu_we), .ldr_we(ldr_we),
    .cpu_addr(cpu_addr), .ldr_addr(ldr_addr), .cpu_wdata(cpu_wdata), .ldr_wdata(ldr_wdata),
    .cpu_ack(cpu_ack), .ldr_ack(ldr_ack), .rdata(rdata), .sw(sw), .hex_out(hex_out),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(req_w1), .ldr_req(1'b0), .cpu_we(1'b0), .ldr_we(1'b0),
    .cpu_addr(16'h0123), .ldr_addr(16'h0000), .cpu_wdata(16'h0000), .ldr_wdata(16'h0000),
    .cpu_ack(cack_w1), .ldr_ack(lack_w1), .rdata(rd_w1), .sw(16'h0000), .hex_out(hex_w1),
    .mem_ce_n(ce_w1), .mem_oe_n(oe_w1), .mem_we_n(we_w1),
    .mem_addr(ma_w1), .mem_wdata(mwd_w1), .mem_rdata(ma_w1 ^ 16'h5A5A)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(req_w15), .ldr_req(1'b0), .cpu_we(1'b0), .ldr_we(1'b0),
    .cpu_addr(16'h0123), .ldr_addr(16'h0000), .cpu_wdata(16'h0000), .ldr_wdata(16'h0000),
    .cpu_ack(cack_w15), .ldr_ack(lack_w15), .rdata(rd_w15), .sw(16'h0000), .hex_out(hex_w15),
    .mem_ce_n(ce_w15), .mem_oe_n(oe_w15), .mem_we_n(we_w15),
    .mem_addr(ma_w15), .mem_wdata(mwd_w15), .mem_rdata(ma_w15 ^ 16'h5A5A)
  );

  // Asynchronous-read SRAM; writes on the rising edge while CE and WE are low.
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (!mem_ce_n && !mem_we_n) sram[mem_addr] <= mem_wdata;
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One transaction from the chosen requester; cycle 1 follows the grant edge.
  task automatic run_txn(input logic is_cpu, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int ack_cyc, output int ack_len,
                         output int wrong_ack, output int oe_cnt, output int we_cnt,
                         output int ce_cnt, output logic [15:0] rd);
    logic own, oth;
    ack_cyc = -1; ack_len = 0; wrong_ack = 0; oe_cnt = 0; we_cnt = 0; ce_cnt = 0;
    rd = 16'h0000;
    @(posedge clk); #1;
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      own = is_cpu ? cpu_ack : ldr_ack;
      oth = is_cpu ? ldr_ack : cpu_ack;
      if (own) begin
        ack_len++;
        if (ack_cyc < 0) begin ack_cyc = k; rd = rdata; end
      end
      if (oth) wrong_ack++;
      if (!mem_ce_n) ce_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) we_cnt++;
      @(posedge clk); #1;
      if (ack_cyc > 0) begin cpu_req = 1'b0; ldr_req = 1'b0; end
      if (ack_cyc > 0 && k >= ack_cyc + 2) break;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec_cnt++; if ({cpu_ack, ldr_ack} !== 2'b00) begin err_cnt++; $display("FAIL reset_acks got %b want 00", {cpu_ack, ldr_ack}); end
    vec_cnt++; if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111) begin err_cnt++; $display("FAIL reset_strobes got %b want 111", {mem_ce_n, mem_oe_n, mem_we_n}); end
    vec_cnt++; if (rdata !== 16'h0000) begin err_cnt++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    vec_cnt++; if (hex_out !== 16'h0000) begin err_cnt++; $display("FAIL reset_hex got %h want 0000", hex_out); end
    vec_cnt++; if ({mem_addr, mem_wdata} !== 32'h0) begin err_cnt++; $display("FAIL reset_addr_wdata got %h want 0", {mem_addr, mem_wdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    int ac, al, wa, oc, wc, cc; logic [15:0] rd;
    preload(16'h3000, 16'hBEEF);
    run_txn(1'b1, 1'b0, 16'h3000, 16'h0000, ac, al, wa, oc, wc, cc, rd);
    vec_cnt++; if (ac !== 3) begin err_cnt++; $display("FAIL read_ack_cycle got %0d want 3", ac); end
    vec_cnt++; if (rd !== 16'hBEEF) begin err_cnt++; $display("FAIL read_rdata got %h want beef", rd); end
    vec_cnt++; if (oc !== 2 || wc !== 0) begin err_cnt++; $display("FAIL read_strobes got oe=%0d we=%0d want oe=2 we=0", oc, wc); end
    vec_cnt++; if (al !== 1 || wa !== 0) begin err_cnt++; $display("FAIL read_ack_pulse got len=%0d ldr=%0d want 1 0", al, wa); end
  endtask

  task automatic test_ldr_write_readback;
    int ac, al, wa, oc, wc, cc; logic [15:0] rd;
    run_txn(1'b0, 1'b1, 16'h0040, 16'h1234, ac, al, wa, oc, wc, cc, rd);
    vec_cnt++; if (ac !== 3 || wa !== 0) begin err_cnt++; $display("FAIL ldr_write_ack got cyc=%0d cpu=%0d want 3 0", ac, wa); end
    vec_cnt++; if (wc !== 2 || oc !== 0) begin err_cnt++; $display("FAIL ldr_write_strobes got we=%0d oe=%0d want 2 0", wc, oc); end
    vec_cnt++; if (rdata !== 16'hBEEF) begin err_cnt++; $display("FAIL write_keeps_rdata got %h want beef", rdata); end
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, ac, al, wa, oc, wc, cc, rd);
    vec_cnt++; if (ac !== 3 || rd !== 16'h1234) begin err_cnt++; $display("FAIL readback got cyc=%0d data=%h want 3 1234", ac, rd); end
  endtask

  task automatic test_io;
    int ac, al, wa, oc, wc, cc; logic [15:0] rd;
    sw = 16'h00A5;
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, ac, al, wa, oc, wc, cc, rd);
    vec_cnt++; if (ac !== 2) begin err_cnt++; $display("FAIL io_read_ack got %0d want 2", ac); end
    vec_cnt++; if (rd !== 16'h00A5) begin err_cnt++; $display("FAIL io_read_data got %h want 00a5", rd); end
    vec_cnt++; if (cc + oc + wc !== 0) begin err_cnt++; $display("FAIL io_read_strobes got %0d want 0", cc + oc + wc); end
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'h0042, ac, al, wa, oc, wc, cc, rd);
    vec_cnt++; if (ac !== 2 || al !== 1) begin err_cnt++; $display("FAIL io_write_ack got cyc=%0d len=%0d want 2 1", ac, al); end
    vec_cnt++; if (hex_out !== 16'h0042) begin err_cnt++; $display("FAIL io_hex got %h want 0042", hex_out); end
    vec_cnt++; if (cc + oc + wc !== 0 || rdata !== 16'h00A5) begin err_cnt++; $display("FAIL io_write_side got strobes=%0d rdata=%h want 0 00a5", cc + oc + wc, rdata); end
  endtask

  task automatic test_reset_mid_access;
    int bad;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h7777;
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if ({mem_ce_n, mem_we_n} !== 2'b00) begin err_cnt++; $display("FAIL pre_reset_strobes got %b want 00", {mem_ce_n, mem_we_n}); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111) begin err_cnt++; $display("FAIL async_reset_strobes got %b want 111", {mem_ce_n, mem_oe_n, mem_we_n}); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack || !mem_ce_n) bad++;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL abort_no_ack got %0d bad cycles want 0", bad); end
    vec_cnt++; if (hex_out !== 16'h0000 || rdata !== 16'h0000) begin err_cnt++; $display("FAIL post_reset_regs got hex=%h rdata=%h want 0 0", hex_out, rdata); end
  endtask

  task automatic test_back_to_back;
    int n, extra; int who [0:7]; int cyc [0:7]; logic [15:0] dat [0:7];
    n = 0; extra = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0040;
    @(posedge clk); #1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (cpu_ack && ldr_ack) extra++;
      else if ((cpu_ack || ldr_ack) && n < 8) begin
        who[n] = cpu_ack ? 0 : 1; cyc[n] = k; dat[n] = rdata; n++;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) extra++;
    end
    vec_cnt++; if (n !== 3 || extra !== 0) begin err_cnt++; $display("FAIL rr_count got %0d acks %0d extra want 3 0", n, extra); end
    if (n == 3) begin
      vec_cnt++; if (who[0] !== 0 || who[1] !== 1 || who[2] !== 0) begin err_cnt++; $display("FAIL rr_order got %0d%0d%0d want 010", who[0], who[1], who[2]); end
      vec_cnt++; if (cyc[0] !== 3 || cyc[1] !== 7 || cyc[2] !== 11) begin err_cnt++; $display("FAIL rr_cycles got %0d %0d %0d want 3 7 11", cyc[0], cyc[1], cyc[2]); end
      vec_cnt++; if (dat[0] !== 16'hBEEF || dat[1] !== 16'h1234 || dat[2] !== 16'hBEEF) begin err_cnt++; $display("FAIL rr_data got %h %h %h want beef 1234 beef", dat[0], dat[1], dat[2]); end
    end
  endtask

  task automatic test_wait_variants;
    int c1, c15; logic [15:0] r1, r15;
    c1 = -1; c15 = -1; r1 = 16'h0000; r15 = 16'h0000;
    @(posedge clk); #1;
    req_w1 = 1'b1; req_w15 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (cack_w1 && c1 < 0) begin c1 = k; r1 = rd_w1; end
      if (cack_w15 && c15 < 0) begin c15 = k; r15 = rd_w15; end
      @(posedge clk); #1;
      if (c1 > 0) req_w1 = 1'b0;
      if (c15 > 0) req_w15 = 1'b0;
    end
    req_w1 = 1'b0; req_w15 = 1'b0;
    vec_cnt++; if (c1 !== 2 || r1 !== 16'h5B79) begin err_cnt++; $display("FAIL wait1_read got cyc=%0d data=%h want 2 5b79", c1, r1); end
    vec_cnt++; if (c15 !== 16 || r15 !== 16'h5B79) begin err_cnt++; $display("FAIL wait15_read got cyc=%0d data=%h want 16 5b79", c15, r15); end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0; ldr_req = 1'b0; cpu_we = 1'b0; ldr_we = 1'b0;
    cpu_addr = 16'h0000; ldr_addr = 16'h0000; cpu_wdata = 16'h0000; ldr_wdata = 16'h0000;
    sw = 16'h0000; pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 16'h0000;
    req_w1 = 1'b0; req_w15 = 1'b0;
    test_reset;
    test_single_read;
    test_ldr_write_readback;
    test_io;
    test_reset_mid_access;
    test_back_to_back;
    test_wait_variants;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory controller between the SLC-3 CPU datapath (MAR/MDR memory cycles) and the program loader. It arbitrates between the two requesters and sequences the SRAM strobes with a fixed wait-state count. It also decodes the memory-mapped I/O word: switch read and hex-display register write. It sits between the CPU core and the board SRAM, in the top-level `slc3` wrapper.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles SRAM strobes stay asserted per access; legal values 1..15.
- `IO_ADDR`, default 16'hFFFF: address decoded as I/O instead of SRAM.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  one clock; reset is asynchronous and active-low.
- `cpu_req`, `ldr_req`  in  1  access request from the CPU and the loader respectively.
- `cpu_we`, `ldr_we`  in  1  1 = write, 0 = read.
- `cpu_addr`, `ldr_addr`  in  16  word address.
- `cpu_wdata`, `ldr_wdata`  in  16  write data.
- `cpu_ack`, `ldr_ack`  out  1  one-cycle completion pulse to the granted requester.
- `rdata`  out  16  registered read data; valid in the ack cycle and held until the next read completes.
- `sw`  in  16  switch inputs, returned on an I/O read.
- `hex_out`  out  16  I/O display register.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1  SRAM strobes, active-low.
- `mem_addr`  out  16  SRAM address.
- `mem_wdata`  out  16  SRAM write data.
- `mem_rdata`  in  16  SRAM read data.

## Operation
- States: IDLE, GRANT, ACCESS, IO, DONE.
- IDLE:
  - If any request is high, select the winner and latch its we/addr/wdata into internal registers.
  - Go to ACCESS if the latched address is not `IO_ADDR`; otherwise go to IO.
  - The GRANT state is only a 1-cycle alias used for clarity; implement it as part of the IDLE→ACCESS/IO transition edge.
- Arbitration:
  - A single requester wins outright.
  - If both requests are high, the winner is the requester not granted last (round-robin).
  - `last_grant` resets to loader, so the CPU wins the first tie.
- ACCESS:
  - Wait counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - `mem_ce_n`=0 for the whole state.
  - Read: `mem_oe_n`=0. Write: `mem_we_n`=0 and `mem_wdata` driven.
  - On the cycle the counter reaches 0: a read captures `mem_rdata` into `rdata`, then the FSM goes to DONE.
- IO (1 cycle), no SRAM strobes:
  - Read: `rdata` <= `sw`.
  - Write: `hex_out` <= latched wdata.
  - Then go to DONE.
- DONE (1 cycle):
  - Assert the ack of the granted requester only; update `last_grant`.
  - Return to IDLE.
- Requester rules:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, on the edge that ends the ack cycle.
  - A req still high in IDLE starts a new transaction.
  - Operands are latched at grant, so changes after grant do not affect the access in progress.
- Request withdrawn before ack: the access still completes and ack still pulses.
- Write completion leaves `rdata` unchanged.

## Timing
- Reset values:
  - State IDLE; `cpu_ack`=`ldr_ack`=0; `rdata`=0; `hex_out`=0.
  - All strobes =1; `mem_addr`=0; `mem_wdata`=0.
  - `last_grant`=loader; wait counter =0.
- Reset assertion mid-access deasserts all strobes and acks immediately (asynchronously) and aborts the transaction without ack.
- Strobes, `mem_addr` and `mem_wdata` are registered outputs. They are glitch-free and stable for every ACCESS cycle.
- SRAM latency, req sampled high in IDLE at edge 0: ACCESS spans cycles 1..`WAIT_CYCLES`; ack high in cycle `WAIT_CYCLES`+1. The default gives ack in cycle 3.
- I/O latency: ack high in cycle 2.
- Back-to-back throughput: one SRAM access per `WAIT_CYCLES`+2 cycles.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t`;
  - requester id typedef `req_id_t` (CPU, LDR);
  - `IO_ADDR_DEFAULT` constant.
- Sub-module `wait_counter`: 4-bit loadable down-counter with a `zero` flag, instantiated once.
- The remainder is one FSM plus the operand and output registers in `mem_arbiter`.

## Test plan
- Reset: drive `Reset`=0 mid-ACCESS of a write -> `mem_we_n`/`mem_ce_n` go 1 immediately; no ack; after release, state IDLE and `hex_out`=0.
- Single CPU read: preload SRAM[16'h3000]=16'hBEEF; `cpu_req` read at 16'h3000 -> `mem_oe_n` low for 2 cycles; `cpu_ack` pulses in cycle 3 with `rdata`=16'hBEEF; `ldr_ack` stays 0.
- Loader write then CPU read-back: loader writes 16'h1234 to 16'h0040, then CPU reads 16'h0040 -> `rdata`=16'h1234.
- Simultaneous requests: both requests held for 3 transactions -> grants CPU, LDR, CPU in order; each ack exactly one cycle.
- I/O: `sw`=16'h00A5 and CPU read at 16'hFFFF -> ack in cycle 2, `rdata`=16'h00A5, no strobes asserted; CPU write 16'h0042 to 16'hFFFF -> `hex_out`=16'h0042.
- `WAIT_CYCLES`=1 and `WAIT_CYCLES`=15 builds: the single-read case gives ack at cycle 2 and cycle 16 respectively.
